// File: rtl/rat_pkg.sv
// Shared types and helpers for the rat-maze path queue and its optional position tracker.
package rat_pkg;

    localparam int unsigned DEPTH_DEFAULT = 256;
    localparam int unsigned POS_MAX       = 16;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    typedef struct packed {
        logic [POS_MAX-1:0] x;
        logic [POS_MAX-1:0] y;
    } pos_t;

    // Computed at full width; callers truncate, which keeps the result modulo 2^POS_W.
    function automatic pos_t next_pos(input logic [POS_MAX-1:0] x,
                                      input logic [POS_MAX-1:0] y,
                                      input dir_t               dir);
        pos_t p;
        p.x = x;
        p.y = y;
        unique case (dir)
            DIR_RIGHT: p.x = x + POS_MAX'(1);
            DIR_DOWN:  p.y = y + POS_MAX'(1);
            DIR_LEFT:  p.x = x - POS_MAX'(1);
            DIR_UP:    p.y = y - POS_MAX'(1);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/rat_path_queue_if.sv
// Controller/display-side bus of the path queue. Position outputs exist only with RAT_PATH_POS_EN.
interface rat_path_queue_if
    import rat_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned DIR_W = 2
`ifdef RAT_PATH_POS_EN
    , parameter int unsigned POS_W = 4
`endif
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             clear;
    logic             enqueue;
    logic [DIR_W-1:0] din;
    logic             dequeue;
    logic             recover;
    logic             emptyq;
    logic             full;
    logic [CNT_W-1:0] count;
    logic [DIR_W-1:0] dout;
    logic             dout_valid;
    logic             overflow;
`ifdef RAT_PATH_POS_EN
    logic [POS_W-1:0] pos_x;
    logic [POS_W-1:0] pos_y;
    logic             pos_valid;
`endif

`ifdef RAT_PATH_POS_EN
    modport master (output clear, enqueue, din, dequeue, recover,
                    input  emptyq, full, count, dout, dout_valid, overflow,
                           pos_x, pos_y, pos_valid);
    modport slave  (input  clear, enqueue, din, dequeue, recover,
                    output emptyq, full, count, dout, dout_valid, overflow,
                           pos_x, pos_y, pos_valid);
`else
    modport master (output clear, enqueue, din, dequeue, recover,
                    input  emptyq, full, count, dout, dout_valid, overflow);
    modport slave  (input  clear, enqueue, din, dequeue, recover,
                    output emptyq, full, count, dout, dout_valid, overflow);
`endif

endinterface

// File: rtl/rat_pos_tracker.sv
// Follows the rat across the grid by applying each replayed move to a wrapping (x,y) position.
module rat_pos_tracker
    import rat_pkg::*;
#(
    parameter int unsigned POS_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             recover,
    input  logic             dout_valid,
    input  logic [1:0]       dout,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             pos_valid
);

    pos_t np;

    always_comb begin
        np = next_pos(POS_MAX'(pos_x), POS_MAX'(pos_y), dir_t'(dout));
    end

    always_ff @(posedge clk) begin
        if (rst || recover) begin
            pos_x     <= '0;
            pos_y     <= '0;
            pos_valid <= 1'b0;
        end else if (dout_valid) begin
            pos_x     <= POS_W'(np.x);
            pos_y     <= POS_W'(np.y);
            pos_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/rat_path_queue.sv
// Linear, non-destructive store of the solved path with replay and rewind.
// Optional position tracker enabled by defining RAT_PATH_POS_EN.
module rat_path_queue
    import rat_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned DIR_W = 2
`ifdef RAT_PATH_POS_EN
    , parameter int unsigned POS_W = 4
`endif
) (
    input  logic               clk,
    input  logic               rst,
    rat_path_queue_if.slave    bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DIR_W-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             flush;
    logic             full_c;
    logic             empty_c;

    assign flush   = rst || bus.clear;
    assign full_c  = (wr_ptr == PW'(DEPTH));
    assign empty_c = (rd_ptr == wr_ptr);

    assign bus.full   = full_c;
    assign bus.emptyq = empty_c;
    assign bus.count  = wr_ptr;

    // Storage is never reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!flush && bus.enqueue && !full_c) begin
            mem[wr_ptr[AW-1:0]] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.dout       <= '0;
            bus.dout_valid <= 1'b0;
            bus.overflow   <= 1'b0;
        end else begin
            bus.dout_valid <= 1'b0;
            if (bus.enqueue) begin
                if (!full_c) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end else begin
                    bus.overflow <= 1'b1;
                end
            end
            // Rewind beats a same-cycle dequeue; an empty queue never bypasses din.
            if (bus.recover) begin
                rd_ptr <= '0;
            end else if (bus.dequeue && !empty_c) begin
                bus.dout       <= mem[rd_ptr[AW-1:0]];
                rd_ptr         <= rd_ptr + PW'(1);
                bus.dout_valid <= 1'b1;
            end
        end
    end

`ifdef RAT_PATH_POS_EN
    rat_pos_tracker #(
        .POS_W (POS_W)
    ) u_pos (
        .clk        (clk),
        .rst        (flush),
        .recover    (bus.recover),
        .dout_valid (bus.dout_valid),
        .dout       (bus.dout),
        .pos_x      (bus.pos_x),
        .pos_y      (bus.pos_y),
        .pos_valid  (bus.pos_valid)
    );
`else
`endif

endmodule
